// File: rtl/env_tick_ctrl.sv
// End-of-test sequencer: ticks the checker channels, latches their stop/verdict,
// decides when the test ends, drains, and holds a single done/passed result.
module env_tick_ctrl #(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned CntWidth      = 32,
  parameter int unsigned TimeoutCycles = 100000,
  parameter int unsigned DrainCycles   = 16,
  parameter bit          FailFast      = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [NumChannels-1:0] chan_stop_req_i,
  input  logic [NumChannels-1:0] chan_passed_i,
  output logic                   tick_o,
  output logic [NumChannels-1:0] stopped_o,
  output logic [CntWidth-1:0]    cycle_cnt_o,
  output logic                   done_o,
  output logic                   test_passed_o,
  output logic                   timeout_o
);

  localparam int unsigned DrainW = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;
  localparam logic [63:0] TimeoutLast = 64'(TimeoutCycles) - 64'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [NumChannels-1:0] stopped_q, stopped_d;
  logic [NumChannels-1:0] new_stops;
  logic                   fail_q, fail_d;
  logic                   timeout_q, timeout_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [DrainW-1:0]      drain_q, drain_d;
  logic                   end_run;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  // True in the last RUN cycle a timeout allows; never true when timeout is disabled.
  function automatic logic is_timeout_cycle(input logic [CntWidth-1:0] v);
    return (TimeoutCycles != 0) && (64'(v) == TimeoutLast);
  endfunction

  always_comb begin
    state_d   = state_q;
    stopped_d = stopped_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    new_stops = '0;
    end_run   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_RUN;
          stopped_d = '0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          drain_d   = '0;
        end
      end
      S_RUN: begin
        // Only the first stop of a channel carries its verdict.
        new_stops = chan_stop_req_i & ~stopped_q;
        stopped_d = stopped_q | new_stops;
        fail_d    = fail_q | (|(new_stops & ~chan_passed_i));
        cnt_d     = sat_inc(cnt_q);
        timeout_d = is_timeout_cycle(cnt_q);
        end_run   = (&stopped_d) | (FailFast && fail_d) | timeout_d;
        if (end_run) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == DrainW'(DrainCycles)) state_d = S_DONE;
        else drain_d = drain_q + DrainW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      stopped_q <= '0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      stopped_q <= stopped_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
    end
  end

  assign tick_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign stopped_o     = stopped_q;
  assign cycle_cnt_o   = cnt_q;
  assign timeout_o     = timeout_q;
  assign test_passed_o = done_o & ~fail_q & ~timeout_q & (&stopped_q);

endmodule
